// File: rtl/debug_bus_pkg.sv
// Shared types and constants for the debug bus host initiator.
package debug_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_ACC = 3'd3,
    ST_WAIT_AVL = 3'd4,
    ST_SEND     = 3'd5
  } dbg_state_e;

  localparam logic [7:0] STATUS_OK          = 8'h00;
  localparam logic [7:0] STATUS_ACC_TIMEOUT = 8'hE1;
  localparam logic [7:0] STATUS_AVL_TIMEOUT = 8'hE2;

  localparam logic [7:0] DBG_ADDR_NONE = 8'hFF;
  localparam logic [7:0] DBG_ADDR_RAM  = 8'h02;

  localparam int FRAME_PAYLOAD_BYTES = 8;
  localparam int RESP_BYTES          = 9;

  // Response image: status in the low byte, result above it, so the
  // serializer can shift out LSB first.
  function automatic logic [71:0] pack_response(input logic [7:0]  status,
                                                input logic [63:0] result);
    return {result, status};
  endfunction

endpackage

// File: rtl/debug_frame_rx.sv
// Byte-to-frame assembler: address byte then 8 payload bytes, LSB first.
// A partial frame is dropped after RX_GAP idle cycles.
module debug_frame_rx
  import debug_bus_pkg::*;
#(
  parameter int RX_GAP = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        frame_valid,
  output logic        frame_abort,
  output logic [7:0]  frame_addr,
  output logic [63:0] frame_payload
);

  localparam int GAP_W = $clog2(RX_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(RX_GAP - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(FRAME_PAYLOAD_BYTES - 1);

  logic             loading_r;
  logic [7:0]       addr_r;
  logic [63:0]      payload_r;
  logic [2:0]       cnt_r;
  logic [GAP_W-1:0] gap_r;
  logic             take_s;

  assign take_s = enable && rx_valid;

  // The completed frame is presented in the cycle of the last byte so the
  // main FSM can enter ISSUE on the very next cycle.
  assign frame_valid   = loading_r && take_s && (cnt_r == LAST_BYTE);
  assign frame_abort   = loading_r && !take_s && (gap_r == GAP_LAST);
  assign frame_addr    = addr_r;
  assign frame_payload = {rx_data, payload_r[63:8]};

  // Frame assembly: latch address, shift payload bytes in at the top, time gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loading_r <= 1'b0;
      addr_r    <= 8'h00;
      payload_r <= 64'd0;
      cnt_r     <= 3'd0;
      gap_r     <= '0;
    end else if (!loading_r) begin
      if (take_s) begin
        loading_r <= 1'b1;
        addr_r    <= rx_data;
        cnt_r     <= 3'd0;
        gap_r     <= '0;
      end
    end else if (take_s) begin
      payload_r <= {rx_data, payload_r[63:8]};
      gap_r     <= '0;
      if (cnt_r == LAST_BYTE) begin
        loading_r <= 1'b0;
        cnt_r     <= 3'd0;
      end else begin
        cnt_r <= cnt_r + 3'd1;
      end
    end else if (gap_r == GAP_LAST) begin
      loading_r <= 1'b0;
      cnt_r     <= 3'd0;
      gap_r     <= '0;
    end else begin
      gap_r <= gap_r + GAP_W'(1);
    end
  end

endmodule

// File: rtl/debug_bus_master.sv
// Host-side debug bus initiator: one bus transaction per received frame,
// 9-byte response (status + 64-bit result) back to the byte transmitter.
module debug_bus_master
  import debug_bus_pkg::*;
#(
  parameter int ACC_TIMEOUT = 1024,
  parameter int AVL_TIMEOUT = 65536,
  parameter int RX_GAP      = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  bus_addr,
  output logic        bus_start,
  inout  wire  [63:0] bus_data,
  input  logic        bus_accepted,
  input  logic        bus_available,
  output logic        busy
);

  localparam int CNT_MAX = (ACC_TIMEOUT > AVL_TIMEOUT) ? ACC_TIMEOUT : AVL_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AVL_LAST  = CNT_W'(AVL_TIMEOUT - 1);
  localparam logic [3:0]       RESP_LAST = 4'(RESP_BYTES - 1);

  dbg_state_e       state_r;
  logic [CNT_W-1:0] timer_r;
  logic [63:0]      payload_r;
  logic [71:0]      resp_r;
  logic [3:0]       byte_idx_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic [7:0]       bus_addr_r;
  logic             bus_start_r;
  logic             busy_r;

  logic             rx_enable_s;
  logic             frame_valid_s;
  logic             frame_abort_s;
  logic [7:0]       frame_addr_s;
  logic [63:0]      frame_payload_s;

  // Bytes arriving while a transaction or response is in flight are dropped.
  assign rx_enable_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);

  debug_frame_rx #(
    .RX_GAP (RX_GAP)
  ) u_frame_rx (
    .clk           (clk),
    .rst           (rst),
    .enable        (rx_enable_s),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_valid   (frame_valid_s),
    .frame_abort   (frame_abort_s),
    .frame_addr    (frame_addr_s),
    .frame_payload (frame_payload_s)
  );

  // Payload is driven only in the ISSUE cycle; reset releases it at once
  // because bus_start_r is cleared asynchronously.
  assign bus_data  = bus_start_r ? payload_r : {64{1'bz}};

  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign bus_addr  = bus_addr_r;
  assign bus_start = bus_start_r;
  assign busy      = busy_r;

  // Bus FSM with timeout counting and the response serializer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      payload_r   <= 64'd0;
      resp_r      <= 72'd0;
      byte_idx_r  <= 4'd0;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      bus_addr_r  <= DBG_ADDR_NONE;
      bus_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rx_valid) begin
            busy_r  <= 1'b1;
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (frame_valid_s) begin
            bus_addr_r  <= frame_addr_s;
            payload_r   <= frame_payload_s;
            bus_start_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end else if (frame_abort_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          bus_start_r <= 1'b0;
          timer_r     <= '0;
          state_r     <= ST_WAIT_ACC;
        end
        ST_WAIT_ACC: begin
          if (bus_accepted) begin
            timer_r <= '0;
            if (bus_available) begin
              resp_r     <= pack_response(STATUS_OK, bus_data);
              byte_idx_r <= 4'd0;
              state_r    <= ST_SEND;
            end else begin
              state_r <= ST_WAIT_AVL;
            end
          end else if (timer_r == ACC_LAST) begin
            resp_r     <= pack_response(STATUS_ACC_TIMEOUT, 64'd0);
            byte_idx_r <= 4'd0;
            state_r    <= ST_SEND;
          end else begin
            timer_r <= timer_r + CNT_W'(1);
          end
        end
        ST_WAIT_AVL: begin
          if (bus_available) begin
            resp_r     <= pack_response(STATUS_OK, bus_data);
            byte_idx_r <= 4'd0;
            state_r    <= ST_SEND;
          end else if (timer_r == AVL_LAST) begin
            resp_r     <= pack_response(STATUS_AVL_TIMEOUT, 64'd0);
            byte_idx_r <= 4'd0;
            state_r    <= ST_SEND;
          end else begin
            timer_r <= timer_r + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (!tx_valid_r) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= resp_r[7:0];
          end else if (tx_ready) begin
            if (byte_idx_r == RESP_LAST) begin
              tx_valid_r <= 1'b0;
              tx_data_r  <= 8'h00;
              bus_addr_r <= DBG_ADDR_NONE;
              busy_r     <= 1'b0;
              state_r    <= ST_IDLE;
            end else begin
              byte_idx_r <= byte_idx_r + 4'd1;
              tx_data_r  <= resp_r[15:8];
              resp_r     <= {8'h00, resp_r[71:8]};
            end
          end
        end
        default: begin
          tx_valid_r  <= 1'b0;
          bus_start_r <= 1'b0;
          bus_addr_r  <= DBG_ADDR_NONE;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
// Directed bench for debug_bus_master with a small debug_ram-like responder.
module tb_debug_bus_master;

  localparam int ACC_T = 16;
  localparam int AVL_T = 32;
  localparam int GAP_T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  bus_addr;
  logic        bus_start;
  wire  [63:0] bus_data;
  logic        bus_accepted;
  logic        bus_available;
  logic        busy;

  int total = 0;
  int bad   = 0;

  debug_bus_master #(
    .ACC_TIMEOUT (ACC_T),
    .AVL_TIMEOUT (AVL_T),
    .RX_GAP      (GAP_T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .bus_addr      (bus_addr),
    .bus_start     (bus_start),
    .bus_data      (bus_data),
    .bus_accepted  (bus_accepted),
    .bus_available (bus_available),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Responder: 0x02 behaves as debug_ram (bit0=1 write -> 0x7B, read -> FF..FF,byte),
  // 0x03 accepts but never delivers, 0x04 accepts and delivers ~payload at once.
  int          avl_delay = 1;
  logic        r_en;
  logic [63:0] r_val;
  logic        pend;
  int          dly;
  logic [7:0]  ram_mem [0:255];

  assign bus_data = r_en ? r_val : {64{1'bz}};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_accepted  <= 1'b0;
      bus_available <= 1'b0;
      r_en          <= 1'b0;
      r_val         <= 64'd0;
      pend          <= 1'b0;
      dly           <= 0;
    end else begin
      bus_accepted  <= 1'b0;
      bus_available <= 1'b0;
      r_en          <= 1'b0;
      if (bus_start) begin
        if (bus_addr == 8'h02) begin
          bus_accepted <= 1'b1;
          pend         <= 1'b1;
          dly          <= avl_delay;
          if (bus_data[0]) begin
            ram_mem[bus_data[15:8]] <= bus_data[63:56];
            r_val <= 64'h7B;
          end else begin
            r_val <= {56'hFF_FFFF_FFFF_FFFF, ram_mem[bus_data[15:8]]};
          end
        end else if (bus_addr == 8'h03) begin
          bus_accepted <= 1'b1;
        end else if (bus_addr == 8'h04) begin
          bus_accepted  <= 1'b1;
          bus_available <= 1'b1;
          r_en          <= 1'b1;
          r_val         <= ~bus_data;
        end
      end else if (pend) begin
        if (dly <= 1) begin
          bus_available <= 1'b1;
          r_en          <= 1'b1;
          pend          <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end

  // Monitor: counts bus_start cycles, times tx_valid rise, flags stray bus drive.
  int          cyc = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          tx_rise_cyc = 0;
  int          drive_errs = 0;
  logic        txv_prev = 1'b0;
  logic [7:0]  issue_addr = 8'h00;
  logic [63:0] issue_data = 64'd0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    txv_prev <= tx_valid;
    if (bus_start) begin
      start_cnt  <= start_cnt + 1;
      start_cyc  <= cyc;
      issue_addr <= bus_addr;
      issue_data <= bus_data;
    end
    if (tx_valid && !txv_prev) tx_rise_cyc <= cyc;
    if (!bus_start && !r_en && (bus_data != 64'd0)) drive_errs <= drive_errs + 1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [63:0] payload;
    logic [7:0]  status;
    logic [63:0] result;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [63:0] p);
    send_byte(a);
    for (int i = 0; i < 8; i++) send_byte(p[8*i +: 8]);
  endtask

  // Collect the 9 response bytes; optionally stall 50 cycles before byte stall_idx.
  task automatic collect(input int stall_idx, output logic [71:0] resp, output int got);
    int   waited;
    logic stalled;
    logic stable;
    logic [7:0] held;
    got     = 0;
    waited  = 0;
    stalled = 1'b0;
    resp    = 72'd0;
    tx_ready = 1'b1;
    while (got < 9 && waited < 600) begin
      @(negedge clk);
      waited++;
      if (got == stall_idx && tx_valid && !stalled) begin
        stalled  = 1'b1;
        held     = tx_data;
        stable   = 1'b1;
        tx_ready = 1'b0;
        for (int k = 0; k < 50; k++) begin
          rx_data  = 8'h02;
          rx_valid = ((k % 7) == 0);
          @(negedge clk);
          if (!tx_valid || tx_data != held) stable = 1'b0;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        check("stall_stable", 72'(stable), 72'd1);
      end
      if (tx_valid && tx_ready) begin
        resp[8*got +: 8] = tx_data;
        got++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int stall_idx);
    int s0;
    int d0;
    int got;
    logic [71:0] resp;
    s0 = start_cnt;
    d0 = drive_errs;
    send_frame(v.addr, v.payload);
    collect(stall_idx, resp, got);
    check("resp_count", 72'(got), 72'd9);
    check("status", 72'(resp[7:0]), 72'(v.status));
    check("result", 72'(resp[71:8]), 72'(v.result));
    check("start_pulses", 72'(start_cnt - s0), 72'd1);
    check("issue_addr", 72'(issue_addr), 72'(v.addr));
    check("issue_data", 72'(issue_data), 72'(v.payload));
    check("latency", 72'(tx_rise_cyc - start_cyc), 72'(v.lat));
    check("bus_released", 72'(drive_errs - d0), 72'd0);
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 72'(busy), 72'd0);
    check("idle_addr", 72'(bus_addr), 72'hFF);
    check("idle_txv", 72'(tx_valid), 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic quiet;
    logic rel;
    vecs[0] = '{8'h02, 64'hA500_0000_0000_1001, 8'h00, 64'h0000_0000_0000_007B, 4};
    vecs[1] = '{8'h02, 64'h0000_0000_0000_1000, 8'h00, 64'hFFFF_FFFF_FFFF_FFA5, 4};
    vecs[2] = '{8'h02, 64'h3C00_0000_0000_1101, 8'h00, 64'h0000_0000_0000_007B, 4};
    vecs[3] = '{8'h02, 64'h0000_0000_0000_1100, 8'h00, 64'hFFFF_FFFF_FFFF_FF3C, 4};
    vecs[4] = '{8'h02, 64'h5A00_0000_0000_1000, 8'h00, 64'hFFFF_FFFF_FFFF_FFA5, 4};
    vecs[5] = '{8'h07, 64'h1122_3344_5566_7788, 8'hE1, 64'd0, ACC_T + 2};
    vecs[6] = '{8'h03, 64'hDEAD_BEEF_0000_0001, 8'hE2, 64'd0, AVL_T + 3};
    vecs[7] = '{8'h04, 64'h0123_4567_89AB_CDEF, 8'h00, 64'hFEDC_BA98_7654_3210, 3};

    rst      = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus_addr", 72'(bus_addr), 72'hFF);
    check("rst_bus_start", 72'(bus_start), 72'd0);
    check("rst_tx_valid", 72'(tx_valid), 72'd0);
    check("rst_tx_data", 72'(tx_data), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], (i == 3) ? 4 : -1);

    // Partial frame dropped after the gap, then a full frame gets the only response.
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    check("gap_busy_hi", 72'(busy), 72'd1);
    quiet = 1'b1;
    repeat (GAP_T + 1) begin
      @(negedge clk);
      if (tx_valid || bus_start) quiet = 1'b0;
    end
    check("gap_quiet", 72'(quiet), 72'd1);
    check("gap_busy_lo", 72'(busy), 72'd0);
    run_vec(vecs[7], -1);

    // Reset during WAIT_AVL.
    avl_delay = 20;
    send_frame(8'h02, 64'h0000_0000_0000_1000);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 72'(busy), 72'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_bus_addr", 72'(bus_addr), 72'hFF);
    check("arst_bus_start", 72'(bus_start), 72'd0);
    check("arst_tx_valid", 72'(tx_valid), 72'd0);
    check("arst_tx_data", 72'(tx_data), 72'd0);
    check("arst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    avl_delay = 1;
    run_vec(vecs[1], -1);

    // Reset during ISSUE releases bus_data before any clock edge.
    send_frame(8'h02, 64'h0000_0000_0000_1000);
    check("issue_seen", 72'(bus_start), 72'd1);
    #1;
    rst = 1'b0;
    #1;
    rel = (bus_data === 64'h0000_0000_0000_1000) ? 1'b0 : 1'b1;
    check("arst_issue_start", 72'(bus_start), 72'd0);
    check("arst_issue_release", 72'(rel), 72'd1);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[4], -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
